// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system ID checker: FSM state encoding,
// Avalon word addresses of the sysid peripheral and default expected values.
package sysid_checker_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_ID  = 3'd1,
    WAIT_ID = 3'd2,
    REQ_TS  = 3'd3,
    WAIT_TS = 3'd4,
    FINISH  = 3'd5
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd0;
  localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1305842390;

endpackage

// File: rtl/sysid_checker_watchdog.sv
// Loadable down-counter that flags the last allowed cycle of a bus read.
// Only instantiated when SYSID_CHECKER_TIMEOUT_EN is defined.
module sysid_checker_watchdog #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_value,
  output logic         expired
);

  logic [W-1:0] count;
  logic [W-1:0] remaining;

  // A load arriving in a counting cycle already counts that cycle.
  always_comb begin
    remaining = load ? load_value : count;
    expired   = en && (remaining == W'(1));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (en) begin
      count <= (remaining != '0) ? remaining - W'(1) : '0;
    end else if (load) begin
      count <= load_value;
    end
  end

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM read initiator that reads the sysid ID word and build timestamp and
// reports registered pass/fail status. Optional read timeout: SYSID_CHECKER_TIMEOUT_EN.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
  parameter bit          AUTO_START         = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output state_t      fsm_state
);

  // Avalon handshake: a request (read/address) is accepted on a rising edge where
  // read=1 and waitrequest=0; it is held unchanged until then, and the next request
  // is only issued after the readdatavalid answering the previous one.

  state_t state;
  logic   auto_armed;
  logic   wd_load;
  logic   wd_en;
  logic   wd_expired;

  assign fsm_state = state;
  assign wd_en     = (state == REQ_ID) || (state == WAIT_ID) ||
                     (state == REQ_TS) || (state == WAIT_TS);

`ifdef SYSID_CHECKER_TIMEOUT_EN
  sysid_checker_watchdog #(.W(16)) u_watchdog (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (wd_load),
    .en         (wd_en),
    .load_value (16'(TIMEOUT_CYCLES)),
    .expired    (wd_expired)
  );
`else
  logic unused_wd;
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign unused_wd  = wd_load ^ wd_en;
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      read       <= 1'b0;
      address    <= ADDR_ID;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      id_ok      <= 1'b0;
      ts_ok      <= 1'b0;
      timeout    <= 1'b0;
      id_value   <= '0;
      ts_value   <= '0;
      auto_armed <= AUTO_START;
      wd_load    <= 1'b0;
    end else begin
      wd_load <= 1'b0;
      if (wd_expired) begin
        // Abandon the outstanding read; uncaptured values keep their old contents.
        read    <= 1'b0;
        timeout <= 1'b1;
        state   <= FINISH;
      end else begin
        case (state)
          IDLE: begin
            if (start || auto_armed) begin
              auto_armed <= 1'b0;
              state      <= REQ_ID;
              read       <= 1'b1;
              address    <= ADDR_ID;
              busy       <= 1'b1;
              done       <= 1'b0;
              pass       <= 1'b0;
              id_ok      <= 1'b0;
              ts_ok      <= 1'b0;
              timeout    <= 1'b0;
              wd_load    <= 1'b1;
            end
          end
          REQ_ID: begin
            if (!waitrequest) begin
              read  <= 1'b0;
              state <= WAIT_ID;
            end
          end
          WAIT_ID: begin
            if (readdatavalid) begin
              id_value <= readdata;
              state    <= REQ_TS;
              read     <= 1'b1;
              address  <= ADDR_TS;
              wd_load  <= 1'b1;
            end
          end
          REQ_TS: begin
            if (!waitrequest) begin
              read  <= 1'b0;
              state <= WAIT_TS;
            end
          end
          WAIT_TS: begin
            if (readdatavalid) begin
              ts_value <= readdata;
              state    <= FINISH;
            end
          end
          FINISH: begin
            id_ok <= (id_value == EXPECTED_ID);
            ts_ok <= (ts_value == EXPECTED_TIMESTAMP);
            pass  <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TIMESTAMP) && !timeout;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
